// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: rise/fall strobes, one-cycle-early rise prediction and half-period lock checking
// for a slow_clk generated on clk. Define CLK_MON_STATS_EN to add the saturating err_count output.
module slow_clk_monitor #(
   parameter int unsigned HALF_PERIOD = 2,
   parameter int unsigned LOCK_EDGES  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       slow_clk,
   output logic       rise,
   output logic       fall,
   output logic       pre_rise,
   output logic       locked,
`ifdef CLK_MON_STATS_EN
   output logic       err,
   output logic [7:0] err_count
`else
   output logic       err
`endif
);

   localparam int unsigned CW = $clog2(2 * HALF_PERIOD) + 1;

   localparam logic [CW-1:0] CNT_SAT   = CW'(2 * HALF_PERIOD);
   localparam logic [CW-1:0] CNT_GOOD  = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] CNT_STALL = CW'(2 * HALF_PERIOD - 1);
   localparam logic [CW-1:0] CNT_PRE   = CW'(HALF_PERIOD - 2);
   localparam logic [3:0]    LOCK_N    = 4'(LOCK_EDGES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic [3:0]    gcnt;
   logic [3:0]    gcnt_nxt;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          edge_seen;
   logic          good_edge;
   logic          stall;

   assign edge_seen = s1 ^ s2;
   assign good_edge = edge_seen && (cnt == CNT_GOOD);
   assign stall     = !edge_seen && (cnt == CNT_STALL);

   assign rise     = s1 & ~s2;
   assign fall     = ~s1 & s2;
   assign locked   = (state == ST_LOCKED);
   assign pre_rise = locked && !s1 && !edge_seen && (cnt == CNT_PRE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         gcnt  <= '0;
         state <= ST_IDLE;
      end else begin
         s1    <= slow_clk;
         s2    <= s1;
         gcnt  <= gcnt_nxt;
         state <= state_nxt;
         if (edge_seen)
            cnt <= '0;
         else if (cnt != CNT_SAT)
            cnt <= cnt + 1'b1;
      end
   end

   // Edge and stall are mutually exclusive, so each state checks the edge first.
   always_comb begin
      state_nxt = state;
      gcnt_nxt  = gcnt;
      err       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (edge_seen) begin
               state_nxt = ST_ACQUIRE;
               gcnt_nxt  = '0;
            end
         end
         ST_ACQUIRE: begin
            if (edge_seen) begin
               if (good_edge) begin
                  gcnt_nxt = gcnt + 4'd1;
                  if (gcnt + 4'd1 == LOCK_N)
                     state_nxt = ST_LOCKED;
               end else begin
                  gcnt_nxt = '0;
               end
            end else if (stall) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (edge_seen) begin
               if (!good_edge) begin
                  err       = 1'b1;
                  state_nxt = ST_ACQUIRE;
                  gcnt_nxt  = '0;
               end
            end else if (stall) begin
               err       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gcnt_nxt  = '0;
         end
      endcase
   end

`ifdef CLK_MON_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_count <= '0;
      else if (err && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

endmodule
